// File: rtl/hdmi_scanout_ctrl_if.sv
// Framebuffer read port of the HDMI scan-out engine.
//   fb_addr   framebuffer word address (AW bits)
//   fb_rd_en  read strobe, high only for active framebuffer pixels
//   fb_data   read data, valid a fixed latency after fb_addr
// master: the scan-out engine. slave: the framebuffer memory.
interface hdmi_scanout_ctrl_if #(
  parameter int AW     = 20,
  parameter int DATA_W = 16
);
  logic [AW-1:0]     fb_addr;
  logic              fb_rd_en;
  logic [DATA_W-1:0] fb_data;

  modport master (output fb_addr, output fb_rd_en, input fb_data);
  modport slave  (input fb_addr, input fb_rd_en, output fb_data);
endinterface

// File: rtl/hdmi_scanout_ctrl.sv
// HDMI scan-out engine: video timing, incremental framebuffer addressing
// with power-of-two pixel/line replication, read-latency compensation,
// run/stop at frame boundaries, test patterns and frame counting.
// Ports:
//   clk_i        pixel clock
//   rst_i        synchronous reset, active high
//   en_i         run request, acted on only at frame boundaries
//   pattern_i    00 framebuffer, 01 solid colour, 10 colour bars, 11 ramp
//   color_i      solid colour value
//   fb           framebuffer read port (address, strobe, data)
//   hs_o, vs_o   syncs, asserted level set by HS_POL / VS_POL
//   de_o         active video
//   data_o       pixel data, zero outside de_o
//   sof_o        pulse on the first de_o of each frame
//   frame_cnt_o  frames started, wraps
//
// state | meaning
// IDLE  | counters parked at (0,0), outputs at idle levels
// RUN   | scanning; leaves only at the last position of a frame
module hdmi_scanout_ctrl #(
  parameter int ACTIVE_H_PIXELS = 1280,
  parameter int H_FRONT_PORCH   = 110,
  parameter int H_SYNC_WIDTH    = 40,
  parameter int H_BACK_PORCH    = 220,
  parameter int ACTIVE_LINES    = 720,
  parameter int V_FRONT_PORCH   = 5,
  parameter int V_SYNC_WIDTH    = 5,
  parameter int V_BACK_PORCH    = 20,
  parameter int HS_POL          = 1,
  parameter int VS_POL          = 1,
  parameter int X_SCALE         = 0,
  parameter int Y_SCALE         = 0,
  parameter int RD_LATENCY      = 2,
  parameter int DATA_W          = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       en_i,
  input  logic [1:0]                 pattern_i,
  input  logic [DATA_W-1:0]          color_i,
  hdmi_scanout_ctrl_if.master        fb,
  output logic                       hs_o,
  output logic                       vs_o,
  output logic                       de_o,
  output logic [DATA_W-1:0]          data_o,
  output logic                       sof_o,
  output logic [15:0]                frame_cnt_o
);
  localparam int HT    = ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
  localparam int VT    = ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;
  localparam int HW    = $clog2(HT);
  localparam int VW    = $clog2(VT);
  localparam int FB_X  = ACTIVE_H_PIXELS >> X_SCALE;
  localparam int FB_Y  = ACTIVE_LINES >> Y_SCALE;
  localparam int AW    = $clog2(FB_X * FB_Y);
  localparam int XW    = (X_SCALE > 0) ? X_SCALE : 1;
  localparam int BAR_W = ACTIVE_H_PIXELS / 8;
  localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int REP   = (DATA_W + 2) / 3;

  // An all-zero mask makes the replication compare always true (scale 0).
  localparam logic [XW-1:0] X_MASK = XW'((1 << X_SCALE) - 1);
  localparam logic [VW-1:0] Y_MASK = VW'((1 << Y_SCALE) - 1);
  localparam logic          HS_ACT = (HS_POL != 0);
  localparam logic          VS_ACT = (VS_POL != 0);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic              act;
    logic              hs;
    logic              vs;
    logic              sof;
    logic              fb_sel;
    logic [DATA_W-1:0] val;
  } side_t;

  state_t state_q, state_d;
  logic   issue_zero;

  logic [HW-1:0]     h_q;
  logic [VW-1:0]     v_q;
  logic [1:0]        pat_q;
  logic [DATA_W-1:0] color_q;
  logic [AW-1:0]     addr_q, base_q;
  logic [XW-1:0]     xsub_q;
  logic [BW-1:0]     bar_px_q;
  logic [2:0]        bar_k_q;
  logic [3*REP-1:0]  bar_rep;
  logic [DATA_W-1:0] pat_val;

  logic run, line_end, last_pos, h_act, v_act, act0;
  side_t side0;
  side_t pipe_q [0:RD_LATENCY];
  side_t tail;

  assign run      = (state_q == RUN);
  assign line_end = (h_q == HW'(HT - 1));
  assign last_pos = line_end && (v_q == VW'(VT - 1));
  assign h_act    = (h_q < HW'(ACTIVE_H_PIXELS));
  assign v_act    = (v_q < VW'(ACTIVE_LINES));
  assign act0     = run && h_act && v_act;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // issue_zero marks the edge after which the counters sit at (0,0) while
  // running; that is where the source selection is captured.
  always_comb begin
    state_d    = state_q;
    issue_zero = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_i) begin
          state_d    = RUN;
          issue_zero = 1'b1;
        end
      end
      RUN: begin
        if (last_pos) begin
          if (!en_i) state_d    = IDLE;
          else       issue_zero = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_q     <= '0;
      v_q     <= '0;
      pat_q   <= '0;
      color_q <= '0;
    end else begin
      if (run && !last_pos) begin
        if (line_end) begin
          h_q <= '0;
          v_q <= v_q + 1'b1;
        end else begin
          h_q <= h_q + 1'b1;
        end
      end else begin
        h_q <= '0;
        v_q <= '0;
      end
      if (issue_zero) begin
        pat_q   <= pattern_i;
        color_q <= color_i;
      end
    end
  end

  // addr_q is the word address for the current position; it steps by one
  // per replicated pixel group and reloads from base_q at each line end.
  always_ff @(posedge clk_i) begin
    if (rst_i || !run || last_pos) begin
      addr_q <= '0;
      base_q <= '0;
      xsub_q <= '0;
    end else if (line_end) begin
      xsub_q <= '0;
      if ((v_q & Y_MASK) == Y_MASK) begin
        base_q <= base_q + AW'(FB_X);
        addr_q <= base_q + AW'(FB_X);
      end else begin
        addr_q <= base_q;
      end
    end else if (act0) begin
      if (xsub_q == X_MASK) begin
        xsub_q <= '0;
        addr_q <= addr_q + 1'b1;
      end else begin
        xsub_q <= xsub_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !run || line_end) begin
      bar_px_q <= '0;
      bar_k_q  <= '0;
    end else if (h_act) begin
      if (bar_px_q == BW'(BAR_W - 1)) begin
        bar_px_q <= '0;
        bar_k_q  <= bar_k_q + 1'b1;
      end else begin
        bar_px_q <= bar_px_q + 1'b1;
      end
    end
  end

  assign bar_rep = {REP{bar_k_q}};

  always_comb begin
    pat_val = '0;
    case (pat_q)
      2'b01:   pat_val = color_q;
      2'b10:   pat_val = bar_rep[3*REP-1 -: DATA_W];
      2'b11:   pat_val = DATA_W'(h_q);
      default: pat_val = '0;
    endcase
  end

  always_comb begin
    side0        = '0;
    side0.act    = act0;
    side0.hs     = run && (h_q >= HW'(ACTIVE_H_PIXELS + H_FRONT_PORCH))
                       && (h_q <  HW'(ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH));
    side0.vs     = run && (v_q >= VW'(ACTIVE_LINES + V_FRONT_PORCH))
                       && (v_q <  VW'(ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH));
    side0.sof    = act0 && (h_q == '0) && (v_q == '0);
    side0.fb_sel = (pat_q == 2'b00);
    side0.val    = pat_val;
  end

  // Timing side-band travels RD_LATENCY stages behind fb_addr so it meets
  // fb_data at the output register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fb.fb_addr  <= '0;
      fb.fb_rd_en <= 1'b0;
      for (int k = 0; k <= RD_LATENCY; k++) pipe_q[k] <= '0;
    end else begin
      fb.fb_addr  <= addr_q;
      fb.fb_rd_en <= act0 && (pat_q == 2'b00);
      pipe_q[0]   <= side0;
      for (int k = 1; k <= RD_LATENCY; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign tail = pipe_q[RD_LATENCY];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hs_o        <= ~HS_ACT;
      vs_o        <= ~VS_ACT;
      de_o        <= 1'b0;
      data_o      <= '0;
      sof_o       <= 1'b0;
      frame_cnt_o <= '0;
    end else begin
      hs_o        <= tail.hs ? HS_ACT : ~HS_ACT;
      vs_o        <= tail.vs ? VS_ACT : ~VS_ACT;
      de_o        <= tail.act;
      data_o      <= !tail.act ? '0 : (tail.fb_sel ? fb.fb_data : tail.val);
      sof_o       <= tail.sof;
      frame_cnt_o <= frame_cnt_o + 16'(tail.sof);
    end
  end
endmodule

// File: tb/tb_hdmi_scanout_ctrl.sv
// Bench for hdmi_scanout_ctrl: an unscaled and a 2x2-replicated instance run
// side by side from the same controls. A position model pushes expected
// outputs per cycle; they are popped when the DUT pipeline delivers them.
module tb_hdmi_scanout_ctrl;
  localparam int HT  = 14;
  localparam int VT  = 7;
  localparam int AW0 = 5;
  localparam int AW1 = 3;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        sof;
    logic [15:0] data0;
    logic [15:0] data1;
    logic [15:0] fcnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i, en_i;
  logic [1:0]  pattern_i;
  logic [15:0] color_i;
  logic        hs0, vs0, de0, sof0, hs1, vs1, de1, sof1;
  logic [15:0] data0, data1, fcnt0, fcnt1;

  hdmi_scanout_ctrl_if #(.AW(AW0), .DATA_W(16)) fb0 ();
  hdmi_scanout_ctrl_if #(.AW(AW1), .DATA_W(16)) fb1 ();

  hdmi_scanout_ctrl #(
    .ACTIVE_H_PIXELS(8), .H_FRONT_PORCH(2), .H_SYNC_WIDTH(2), .H_BACK_PORCH(2),
    .ACTIVE_LINES(4), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(1), .V_BACK_PORCH(1),
    .HS_POL(1), .VS_POL(1), .X_SCALE(0), .Y_SCALE(0), .RD_LATENCY(2), .DATA_W(16)
  ) dut0 (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .pattern_i(pattern_i), .color_i(color_i),
    .fb(fb0.master), .hs_o(hs0), .vs_o(vs0), .de_o(de0), .data_o(data0),
    .sof_o(sof0), .frame_cnt_o(fcnt0)
  );

  hdmi_scanout_ctrl #(
    .ACTIVE_H_PIXELS(8), .H_FRONT_PORCH(2), .H_SYNC_WIDTH(2), .H_BACK_PORCH(2),
    .ACTIVE_LINES(4), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(1), .V_BACK_PORCH(1),
    .HS_POL(1), .VS_POL(1), .X_SCALE(1), .Y_SCALE(1), .RD_LATENCY(2), .DATA_W(16)
  ) dut1 (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .pattern_i(pattern_i), .color_i(color_i),
    .fb(fb1.master), .hs_o(hs1), .vs_o(vs1), .de_o(de1), .data_o(data1),
    .sof_o(sof1), .frame_cnt_o(fcnt1)
  );

  // Memories return the address itself, two cycles later.
  logic [AW0-1:0] m0_d1, m0_d2;
  logic [AW1-1:0] m1_d1, m1_d2;
  always @(posedge clk) begin
    m0_d1 <= fb0.fb_addr;
    m0_d2 <= m0_d1;
    m1_d1 <= fb1.fb_addr;
    m1_d2 <= m1_d1;
  end
  assign fb0.fb_data = 16'(m0_d2);
  assign fb1.fb_data = 16'(m1_d2);

  logic [15:0] bars [8] = '{16'h0000, 16'h2492, 16'h4924, 16'h6DB6,
                            16'h9249, 16'hB6DB, 16'hDB6D, 16'hFFFF};

  exp_t        exp_q [$];
  logic [AW1-1:0] addr1_q [$];

  int errors = 0;
  int checks = 0;

  logic        drv_rst, drv_en;
  logic [1:0]  drv_pat;
  logic [15:0] drv_col;

  int          m_run, m_h, m_v, m_cnt;
  logic [1:0]  m_pat;
  logic [15:0] m_col;
  logic        prev_rd;
  int          prev_addr;
  int          cyc, start_cyc, last_sof;
  logic        armed, first_sof_done;
  int          pre_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    logic act;
    e     = '0;
    act   = (m_run != 0) && (m_h < 8) && (m_v < 4);
    e.hs  = (m_run != 0) && (m_h == 10 || m_h == 11);
    e.vs  = (m_run != 0) && (m_v == 5);
    e.de  = act;
    e.sof = act && (m_h == 0) && (m_v == 0);
    if (act) begin
      case (m_pat)
        2'b00: begin
          e.data0 = 16'(m_v * 8 + m_h);
          e.data1 = 16'((m_v / 2) * 4 + (m_h / 2));
        end
        2'b01: begin e.data0 = m_col;       e.data1 = m_col;       end
        2'b10: begin e.data0 = bars[m_h];   e.data1 = bars[m_h];   end
        default: begin e.data0 = 16'(m_h);  e.data1 = 16'(m_h);    end
      endcase
    end
    return e;
  endfunction

  task automatic tick();
    exp_t e, x;
    logic cur_rd;
    @(negedge clk);
    cyc++;
    if (armed) begin
      check_val("rd_en0", 32'(fb0.fb_rd_en), 32'(prev_rd));
      check_val("rd_en1", 32'(fb1.fb_rd_en), 32'(prev_rd));
      if (prev_rd) check_val("addr0", 32'(fb0.fb_addr), 32'(prev_addr));
      if (fb1.fb_rd_en === 1'b1) begin
        if (addr1_q.size() == 0) check_val("addr1_unexpected_rd", 32'(fb1.fb_rd_en), 32'(0));
        else                     check_val("addr1", 32'(fb1.fb_addr), 32'(addr1_q.pop_front()));
      end
    end
    e = model_out();
    if (e.sof) m_cnt++;
    e.fcnt = 16'(m_cnt);
    exp_q.push_back(e);
    if (exp_q.size() > 4) begin
      x = exp_q.pop_front();
      if (armed) begin
        check_val("hs0",   32'(hs0),   32'(x.hs));
        check_val("vs0",   32'(vs0),   32'(x.vs));
        check_val("de0",   32'(de0),   32'(x.de));
        check_val("sof0",  32'(sof0),  32'(x.sof));
        check_val("data0", 32'(data0), 32'(x.data0));
        check_val("fcnt0", 32'(fcnt0), 32'(x.fcnt));
        check_val("hs1",   32'(hs1),   32'(x.hs));
        check_val("vs1",   32'(vs1),   32'(x.vs));
        check_val("de1",   32'(de1),   32'(x.de));
        check_val("sof1",  32'(sof1),  32'(x.sof));
        check_val("data1", 32'(data1), 32'(x.data1));
        check_val("fcnt1", 32'(fcnt1), 32'(x.fcnt));
      end
    end
    if (armed && sof0 === 1'b1) begin
      if (!first_sof_done) begin
        check_val("sof_latency", 32'(cyc - start_cyc), 32'(4));
        check_val("fcnt_first", 32'(fcnt0), 32'(1));
        first_sof_done = 1'b1;
      end
      if (last_sof > 0) check_val("frame_period", 32'(cyc - last_sof), 32'(98));
      last_sof = cyc;
    end

    cur_rd    = (m_run != 0) && (m_h < 8) && (m_v < 4) && (m_pat == 2'b00);
    prev_rd   = cur_rd;
    prev_addr = m_v * 8 + m_h;
    if (cur_rd) addr1_q.push_back(AW1'((m_v / 2) * 4 + (m_h / 2)));

    rst_i     = drv_rst;
    en_i      = drv_en;
    pattern_i = drv_pat;
    color_i   = drv_col;

    if (drv_rst) begin
      m_run = 0; m_h = 0; m_v = 0; m_cnt = 0; m_pat = 2'b00; m_col = 16'h0;
      exp_q.delete();
      repeat (4) exp_q.push_back('0);
      addr1_q.delete();
      prev_rd        = 1'b0;
      armed          = 1'b1;
      first_sof_done = 1'b0;
      last_sof       = 0;
    end else if (m_run == 0) begin
      if (drv_en) begin
        m_run     = 1;
        m_pat     = drv_pat;
        m_col     = drv_col;
        start_cyc = cyc + 1;
      end
    end else if (m_h == HT - 1 && m_v == VT - 1) begin
      m_h = 0;
      m_v = 0;
      if (!drv_en) begin
        m_run    = 0;
        last_sof = 0;
      end else begin
        m_pat = drv_pat;
        m_col = drv_col;
      end
    end else if (m_h == HT - 1) begin
      m_h = 0;
      m_v++;
    end else begin
      m_h++;
    end
  endtask

  task automatic wait_pos(input int h, input int v, input int limit);
    int n;
    n = 0;
    while (!(m_run != 0 && m_h == h && m_v == v)) begin
      if (n >= limit) begin
        check_val("wait_timeout_h", 32'(m_h), 32'(h));
        check_val("wait_timeout_v", 32'(m_v), 32'(v));
        break;
      end
      tick();
      n++;
    end
  endtask

  initial begin
    cyc = 0; start_cyc = 0; last_sof = 0; armed = 1'b0; first_sof_done = 1'b0;
    m_run = 0; m_h = 0; m_v = 0; m_cnt = 0; m_pat = 2'b00; m_col = 16'h0;
    prev_rd = 1'b0; prev_addr = 0; pre_cnt = 0;
    drv_rst = 1'b1; drv_en = 1'b0; drv_pat = 2'b00; drv_col = 16'h0;
    rst_i = 1'b1; en_i = 1'b0; pattern_i = 2'b00; color_i = 16'h0;

    repeat (3) tick();
    drv_rst = 1'b0;
    repeat (50) begin
      tick();
      check_val("idle_addr0", 32'(fb0.fb_addr), 32'(0));
      check_val("idle_fcnt",  32'(fcnt0), 32'(0));
    end

    // Two framebuffer frames: timing, alignment, scaled addressing and wrap.
    drv_en = 1'b1;
    repeat (2 * 98 + 1) tick();

    // Bars requested mid-frame; they must start only with the next frame.
    wait_pos(0, 2, 200);
    drv_pat = 2'b10;
    wait_pos(0, 0, 200);
    wait_pos(0, 2, 200);
    drv_pat = 2'b01;
    drv_col = 16'hA5A5;
    wait_pos(0, 0, 200);
    wait_pos(0, 2, 200);
    drv_pat = 2'b00;

    // Stop requested mid-frame: the frame finishes, then idle.
    wait_pos(0, 0, 200);
    pre_cnt = int'(fcnt0);
    wait_pos(3, 1, 200);
    drv_en = 1'b0;
    repeat (120) tick();
    check_val("stop_cnt",  32'(fcnt0), 32'(pre_cnt + 1));
    check_val("stop_de",   32'(de0), 32'(0));
    check_val("stop_addr", 32'(fb0.fb_addr), 32'(0));

    // Reset in the middle of a line.
    drv_en = 1'b1;
    wait_pos(4, 1, 200);
    drv_rst = 1'b1;
    tick();
    drv_rst = 1'b0;
    drv_en  = 1'b0;
    tick();
    check_val("rst_de",   32'(de0), 32'(0));
    check_val("rst_hs",   32'(hs0), 32'(0));
    check_val("rst_fcnt", 32'(fcnt0), 32'(0));
    check_val("rst_rd",   32'(fb0.fb_rd_en), 32'(0));
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
